// File: rtl/vga_code_gen.sv
// vga_code_gen: 640x480@60 Hz pixel-stream generator with a ROWS x COLS board
// of 3-bit colour codes. Produces hsync/vsync/blank_n/code/pix_tick/frame_start
// from the 50 MHz clock using a divide-by-two pixel tick and a 3-stage pipeline
// (S0 counters, S1 cell/sync registers, S2 board read and output registers).
// Optional feature macro: GRID_LINES_EN (grey 1-pixel grid on cell boundaries).
module vga_code_gen #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int CELL_W   = 80,
  parameter int CELL_H   = 80,
  parameter int COLS     = 8,
  parameter int ROWS     = 6
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_wr_en,
  input  logic [2:0] i_wr_row,
  input  logic [2:0] i_wr_col,
  input  logic [2:0] i_wr_code,
  output logic       o_hsync,
  output logic       o_vsync,
  output logic       o_blank_n,
  output logic [2:0] o_code,
  output logic       o_pix_tick,
  output logic       o_frame_start
);

  // ---------------------------------------------------------------------------
  // Derived geometry
  // ---------------------------------------------------------------------------
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int H_W     = $clog2(H_TOTAL);
  localparam int V_W     = $clog2(V_TOTAL);
  localparam int XS_W    = $clog2(CELL_W + 1);
  localparam int YS_W    = $clog2(CELL_H + 1);
  // Cell counters keep running through the blanking region, so size them for
  // the whole line/frame rather than just the board.
  localparam int CC_W    = $clog2(H_TOTAL / CELL_W + 2);
  localparam int CR_W    = $clog2(V_TOTAL / CELL_H + 2);
  localparam int CELLS   = ROWS * COLS;
  localparam int IDX_W   = $clog2(CELLS);

  localparam logic [H_W-1:0]  H_LAST    = H_W'(H_TOTAL - 1);
  localparam logic [H_W-1:0]  H_ACT_L   = H_W'(H_ACTIVE);
  localparam logic [H_W-1:0]  HS_START  = H_W'(H_ACTIVE + H_FP);
  localparam logic [H_W-1:0]  HS_STOP   = H_W'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [V_W-1:0]  V_LAST    = V_W'(V_TOTAL - 1);
  localparam logic [V_W-1:0]  V_ACT_L   = V_W'(V_ACTIVE);
  localparam logic [V_W-1:0]  VS_START  = V_W'(V_ACTIVE + V_FP);
  localparam logic [V_W-1:0]  VS_STOP   = V_W'(V_ACTIVE + V_FP + V_SYNC - 1);
  localparam logic [XS_W-1:0] XS_LAST   = XS_W'(CELL_W - 1);
  localparam logic [YS_W-1:0] YS_LAST   = YS_W'(CELL_H - 1);
  localparam logic [CC_W-1:0] COLS_CC   = CC_W'(COLS);
  localparam logic [CR_W-1:0] ROWS_CR   = CR_W'(ROWS);
  localparam logic [3:0]      COLS_WR   = 4'(COLS);
  localparam logic [3:0]      ROWS_WR   = 4'(ROWS);
  localparam logic [2:0]      CODE_BLK  = 3'd0;
`ifdef GRID_LINES_EN
  localparam logic [2:0]      CODE_GRID = 3'd6;
`endif

  // Flat board address: row-major, only meaningful for in-range row/col.
  function automatic logic [IDX_W-1:0] cell_index(input logic [IDX_W-1:0] row,
                                                   input logic [IDX_W-1:0] col);
    cell_index = row * IDX_W'(COLS) + col;
  endfunction

  // ---------------------------------------------------------------------------
  // Declarations
  // ---------------------------------------------------------------------------
  logic            r_phase;
  logic            w_tick;

  logic [H_W-1:0]  r_h;
  logic [V_W-1:0]  r_v;
  logic [XS_W-1:0] r_x_sub;
  logic [YS_W-1:0] r_y_sub;
  logic [CC_W-1:0] r_cell_col;
  logic [CR_W-1:0] r_cell_row;

  logic [H_W-1:0]  w_h_nxt;
  logic [V_W-1:0]  w_v_nxt;
  logic [XS_W-1:0] w_xs_nxt;
  logic [YS_W-1:0] w_ys_nxt;
  logic [CC_W-1:0] w_cc_nxt;
  logic [CR_W-1:0] w_cr_nxt;

  logic            w_hsync_raw;
  logic            w_vsync_raw;
  logic            w_vis_raw;
  logic            w_frame0_raw;
  logic            w_in_board_raw;

  logic [CC_W-1:0] r1_cell_col;
  logic [CR_W-1:0] r1_cell_row;
  logic            r1_hsync;
  logic            r1_vsync;
  logic            r1_vis;
  logic            r1_frame0;
  logic            r1_in_board;
`ifdef GRID_LINES_EN
  logic [XS_W-1:0] r1_x_sub;
  logic [YS_W-1:0] r1_y_sub;
`endif

  logic [2:0]      r_board [0:CELLS-1];
  logic            w_wr_ok;
  logic [IDX_W-1:0] w_wr_idx;
  logic [IDX_W-1:0] w_rd_idx;
  logic [2:0]      w_cell_code;
  logic [2:0]      w_pix_code;

  logic            r_hsync;
  logic            r_vsync;
  logic            r_blank_n;
  logic [2:0]      r_code;
  logic            r_pix_tick;
  logic            r_frame_start;

  // ---------------------------------------------------------------------------
  // Pixel tick divider
  // ---------------------------------------------------------------------------
  assign w_tick = r_phase;

  // Phase toggles every clk; a pixel tick is the clk where phase is high.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_phase <= 1'b0;
    end else begin
      r_phase <= ~r_phase;
    end
  end

  // ---------------------------------------------------------------------------
  // S0: raster counters and cell sub-counters
  // ---------------------------------------------------------------------------
  // Next raster position; cell sub-counters track h/v so no divider is needed.
  always_comb begin
    w_h_nxt  = r_h;
    w_v_nxt  = r_v;
    w_xs_nxt = r_x_sub;
    w_ys_nxt = r_y_sub;
    w_cc_nxt = r_cell_col;
    w_cr_nxt = r_cell_row;
    if (r_h == H_LAST) begin
      w_h_nxt  = '0;
      w_xs_nxt = '0;
      w_cc_nxt = '0;
      if (r_v == V_LAST) begin
        w_v_nxt  = '0;
        w_ys_nxt = '0;
        w_cr_nxt = '0;
      end else begin
        w_v_nxt = r_v + V_W'(1'b1);
        if (r_y_sub == YS_LAST) begin
          w_ys_nxt = '0;
          w_cr_nxt = r_cell_row + CR_W'(1'b1);
        end else begin
          w_ys_nxt = r_y_sub + YS_W'(1'b1);
        end
      end
    end else begin
      w_h_nxt = r_h + H_W'(1'b1);
      if (r_x_sub == XS_LAST) begin
        w_xs_nxt = '0;
        w_cc_nxt = r_cell_col + CC_W'(1'b1);
      end else begin
        w_xs_nxt = r_x_sub + XS_W'(1'b1);
      end
    end
  end

  // Raster counters advance only on pixel ticks.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_h        <= '0;
      r_v        <= '0;
      r_x_sub    <= '0;
      r_y_sub    <= '0;
      r_cell_col <= '0;
      r_cell_row <= '0;
    end else if (w_tick) begin
      r_h        <= w_h_nxt;
      r_v        <= w_v_nxt;
      r_x_sub    <= w_xs_nxt;
      r_y_sub    <= w_ys_nxt;
      r_cell_col <= w_cc_nxt;
      r_cell_row <= w_cr_nxt;
    end
  end

  // Raw (unaligned) sync, visibility and frame-origin decode from S0.
  always_comb begin
    w_hsync_raw    = 1'b1;
    w_vsync_raw    = 1'b1;
    if ((r_h >= HS_START) && (r_h <= HS_STOP)) begin
      w_hsync_raw = 1'b0;
    end else begin
      w_hsync_raw = 1'b1;
    end
    if ((r_v >= VS_START) && (r_v <= VS_STOP)) begin
      w_vsync_raw = 1'b0;
    end else begin
      w_vsync_raw = 1'b1;
    end
    w_vis_raw      = (r_h < H_ACT_L) && (r_v < V_ACT_L);
    w_frame0_raw   = (r_h == '0) && (r_v == '0);
    w_in_board_raw = (r_cell_col < COLS_CC) && (r_cell_row < ROWS_CR);
  end

  // ---------------------------------------------------------------------------
  // S1: cell coordinates and raw timing
  // ---------------------------------------------------------------------------
  // Capture cell position and raw sync on each tick.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r1_cell_col <= '0;
      r1_cell_row <= '0;
      r1_hsync    <= 1'b1;
      r1_vsync    <= 1'b1;
      r1_vis      <= 1'b0;
      r1_frame0   <= 1'b0;
      r1_in_board <= 1'b0;
    end else if (w_tick) begin
      r1_cell_col <= r_cell_col;
      r1_cell_row <= r_cell_row;
      r1_hsync    <= w_hsync_raw;
      r1_vsync    <= w_vsync_raw;
      r1_vis      <= w_vis_raw;
      r1_frame0   <= w_frame0_raw;
      r1_in_board <= w_in_board_raw;
    end
  end

`ifdef GRID_LINES_EN
  // Sub-cell position, needed only to locate grid lines.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r1_x_sub <= '0;
      r1_y_sub <= '0;
    end else if (w_tick) begin
      r1_x_sub <= r_x_sub;
      r1_y_sub <= r_y_sub;
    end
  end
`endif

  // ---------------------------------------------------------------------------
  // Board register file
  // ---------------------------------------------------------------------------
  assign w_wr_ok  = i_wr_en && ({1'b0, i_wr_row} < ROWS_WR) && ({1'b0, i_wr_col} < COLS_WR);
  assign w_wr_idx = cell_index(IDX_W'(i_wr_row), IDX_W'(i_wr_col));
  assign w_rd_idx = cell_index(IDX_W'(r1_cell_row), IDX_W'(r1_cell_col));

  // Game-logic writes land on any clk edge; out-of-range targets are dropped.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      for (int i = 0; i < CELLS; i++) begin
        r_board[i] <= 3'd0;
      end
    end else if (w_wr_ok) begin
      r_board[w_wr_idx] <= i_wr_code;
    end
  end

  // ---------------------------------------------------------------------------
  // S2: board read and pixel code selection
  // ---------------------------------------------------------------------------
  // Pick the code for the S1 pixel; a same-edge write is not yet visible here.
  always_comb begin
    w_cell_code = CODE_BLK;
    w_pix_code  = CODE_BLK;
    if (r1_in_board) begin
      w_cell_code = r_board[w_rd_idx];
    end else begin
      w_cell_code = CODE_BLK;
    end
`ifdef GRID_LINES_EN
    if (r1_vis && ((r1_x_sub == '0) || (r1_y_sub == '0))) begin
      w_pix_code = CODE_GRID;
    end else if (r1_vis) begin
      w_pix_code = w_cell_code;
    end else begin
      w_pix_code = CODE_BLK;
    end
`else
    if (r1_vis) begin
      w_pix_code = w_cell_code;
    end else begin
      w_pix_code = CODE_BLK;
    end
`endif
  end

  // Output register: all pixel outputs update together on each tick.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_hsync       <= 1'b1;
      r_vsync       <= 1'b1;
      r_blank_n     <= 1'b0;
      r_code        <= 3'd0;
      r_pix_tick    <= 1'b0;
      r_frame_start <= 1'b0;
    end else begin
      r_pix_tick <= w_tick;
      if (w_tick) begin
        r_hsync       <= r1_hsync;
        r_vsync       <= r1_vsync;
        r_blank_n     <= r1_vis;
        r_code        <= w_pix_code;
        r_frame_start <= r1_frame0;
      end else begin
        r_frame_start <= 1'b0;
      end
    end
  end

  assign o_hsync       = r_hsync;
  assign o_vsync       = r_vsync;
  assign o_blank_n     = r_blank_n;
  assign o_code        = r_code;
  assign o_pix_tick    = r_pix_tick;
  assign o_frame_start = r_frame_start;

endmodule

// File: tb/tb_vga_code_gen.sv
// Directed bench for vga_code_gen. One instance uses full 640x480 timing for
// reset/start-up and line timing; a second, shrunken instance (32x12 visible,
// 4x2 cells, same 8x6 board) keeps whole-frame checks short.
module tb_vga_code_gen;

  // Shrunken geometry for the small instance
  localparam int SH_ACT = 32;
  localparam int SH_TOT = 40;   // 32 + 2 + 4 + 2
  localparam int SV_ACT = 12;
  localparam int SV_TOT = 17;   // 12 + 1 + 2 + 2
  localparam int S_CW   = 4;
  localparam int S_CH   = 2;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       wr_en;
  logic [2:0] wr_row, wr_col, wr_code;

  logic       d_hs, d_vs, d_bn, d_pt, d_fs;
  logic [2:0] d_code;
  logic       s_hs, s_vs, s_bn, s_pt, s_fs;
  logic [2:0] s_code;

  int checks   = 0;
  int failures = 0;
  logic [2:0] model [0:47];

  always #5 clk = ~clk;

  vga_code_gen u_def (
    .i_clk(clk), .i_rst_n(rst_n), .i_wr_en(wr_en), .i_wr_row(wr_row),
    .i_wr_col(wr_col), .i_wr_code(wr_code), .o_hsync(d_hs), .o_vsync(d_vs),
    .o_blank_n(d_bn), .o_code(d_code), .o_pix_tick(d_pt), .o_frame_start(d_fs)
  );

  vga_code_gen #(
    .H_ACTIVE(32), .H_FP(2), .H_SYNC(4), .H_BP(2),
    .V_ACTIVE(12), .V_FP(1), .V_SYNC(2), .V_BP(2),
    .CELL_W(4), .CELL_H(2), .COLS(8), .ROWS(6)
  ) u_small (
    .i_clk(clk), .i_rst_n(rst_n), .i_wr_en(wr_en), .i_wr_row(wr_row),
    .i_wr_col(wr_col), .i_wr_code(wr_code), .o_hsync(s_hs), .o_vsync(s_vs),
    .o_blank_n(s_bn), .o_code(s_code), .o_pix_tick(s_pt), .o_frame_start(s_fs)
  );

`ifdef GRID_LINES_EN
  localparam logic [2:0] ORIGIN_CODE = 3'd6;
  localparam int EXP_N6_ANY = 240;  // 96 column-line + 192 row-line - 48 overlap
  localparam int EXP_N5     = 3;    // cell (2,3) minus its grid pixels
`else
  localparam logic [2:0] ORIGIN_CODE = 3'd0;
  localparam int EXP_N6_ANY = 0;
  localparam int EXP_N5     = 8;    // full 4x2 cell
`endif

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic wait_sfs(input string tag);
    bit ok = 1'b0;
    for (int i = 0; i < 3000 && !ok; i++) begin
      @(negedge clk);
      if (s_fs === 1'b1) ok = 1'b1;
    end
    chk(tag, 32'(ok), 32'd1);
  endtask

  task automatic do_write(input logic [2:0] r, input logic [2:0] c, input logic [2:0] v);
    wr_en = 1'b1; wr_row = r; wr_col = c; wr_code = v;
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  // Walk one whole frame of the small instance comparing against the model.
  task automatic scan_frame(input string tag, output int mism, output int n5, output int n6);
    int x, y;
    logic       e_vis, e_hs, e_vs;
    logic [2:0] e_code;
    mism = 0; n5 = 0; n6 = 0;
    wait_sfs({tag, "_fs"});
    for (int t = 0; t < SH_TOT * SV_TOT; t++) begin
      x = t % SH_TOT;
      y = t / SH_TOT;
      e_vis = (x < SH_ACT) && (y < SV_ACT);
      e_hs  = !((x >= 34) && (x <= 37));
      e_vs  = !((y >= 13) && (y <= 14));
      if (!e_vis) e_code = 3'd0;
`ifdef GRID_LINES_EN
      else if ((x % S_CW == 0) || (y % S_CH == 0)) e_code = 3'd6;
`endif
      else e_code = model[(y / S_CH) * 8 + (x / S_CW)];
      if (s_pt !== 1'b1 || s_bn !== e_vis || s_hs !== e_hs || s_vs !== e_vs || s_code !== e_code)
        mism++;
      if (s_code === 3'd5) n5++;
      if (s_code === 3'd6) n6++;
      repeat (2) @(negedge clk);
    end
  endtask

  initial begin
    bit ok, done, prev_hs, prev_vs;
    int n_tick, n_low, n_vis, n_lines, n_lines_vlow;
    int mism, n5, n6;

    rst_n = 1'b0; wr_en = 1'b0; wr_row = 3'd0; wr_col = 3'd0; wr_code = 3'd0;
    for (int i = 0; i < 48; i++) model[i] = 3'd0;

    // ---- reset values ----
    repeat (10) @(negedge clk);
    chk("rst_hsync",  32'(d_hs),   32'd1);
    chk("rst_vsync",  32'(d_vs),   32'd1);
    chk("rst_blank",  32'(d_bn),   32'd0);
    chk("rst_code",   32'(d_code), 32'd0);
    chk("rst_tick",   32'(d_pt),   32'd0);
    chk("rst_fs",     32'(d_fs),   32'd0);
    chk("rst_s_fs",   32'(s_fs),   32'd0);

    // ---- start-up latency: frame_start 4 clk after release ----
    rst_n = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      @(negedge clk);
      chk("fs_early",   32'(d_fs), 32'd0);
      chk("s_fs_early", 32'(s_fs), 32'd0);
    end
    @(negedge clk);
    chk("fs_at4",     32'(d_fs),   32'd1);
    chk("bn_at4",     32'(d_bn),   32'd1);
    chk("code_at4",   32'(d_code), 32'(ORIGIN_CODE));
    chk("tick_at4",   32'(d_pt),   32'd1);
    chk("s_fs_at4",   32'(s_fs),   32'd1);
    @(negedge clk);
    chk("fs_width",   32'(d_fs),   32'd0);
    chk("tick_off",   32'(d_pt),   32'd0);

    // ---- full-size line timing ----
    ok = 1'b0; prev_hs = d_hs;
    for (int i = 0; i < 4000 && !ok; i++) begin
      @(negedge clk);
      if (prev_hs === 1'b1 && d_hs === 1'b0) ok = 1'b1;
      prev_hs = d_hs;
    end
    chk("hs_fall_found", 32'(ok), 32'd1);
    n_tick = 0; n_low = 0; n_vis = 0; done = 1'b0;
    for (int i = 0; i < 4000 && !done; i++) begin
      if (d_pt === 1'b1) begin
        n_tick++;
        if (d_hs === 1'b0) n_low++;
        if (d_bn === 1'b1) n_vis++;
      end
      prev_hs = d_hs;
      @(negedge clk);
      if (prev_hs === 1'b1 && d_hs === 1'b0) done = 1'b1;
    end
    chk("line_done",   32'(done), 32'd1);
    chk("line_ticks",  32'(n_tick), 32'd800);
    chk("hsync_low",   32'(n_low),  32'd96);
    chk("line_vis",    32'(n_vis),  32'd640);

    // ---- small-instance frame timing ----
    ok = 1'b0; prev_vs = s_vs;
    for (int i = 0; i < 4000 && !ok; i++) begin
      @(negedge clk);
      if (prev_vs === 1'b1 && s_vs === 1'b0) ok = 1'b1;
      prev_vs = s_vs;
    end
    chk("vs_fall_found", 32'(ok), 32'd1);
    n_tick = 0; n_low = 0; n_vis = 0; n_lines = 0; n_lines_vlow = 0; done = 1'b0;
    prev_hs = s_hs; prev_vs = s_vs;
    for (int i = 0; i < 4000 && !done; i++) begin
      if (s_pt === 1'b1) begin
        n_tick++;
        if (s_vs === 1'b0) n_low++;
        if (s_bn === 1'b1) n_vis++;
      end
      @(negedge clk);
      if (prev_hs === 1'b1 && s_hs === 1'b0) begin
        n_lines++;
        if (s_vs === 1'b0) n_lines_vlow++;
      end
      if (prev_vs === 1'b1 && s_vs === 1'b0) done = 1'b1;
      prev_hs = s_hs; prev_vs = s_vs;
    end
    chk("frame_done",     32'(done),         32'd1);
    chk("frame_ticks",    32'(n_tick),       32'd680);
    chk("frame_lines",    32'(n_lines),      32'd17);
    chk("vsync_lines",    32'(n_lines_vlow), 32'd2);
    chk("vsync_ticks",    32'(n_low),        32'd80);
    chk("frame_vis",      32'(n_vis),        32'd384);

    // ---- cell write (2,3)=5 ----
    do_write(3'd2, 3'd3, 3'd5);
    model[2*8+3] = 3'd5;
    scan_frame("cell", mism, n5, n6);
    chk("cell_mism", 32'(mism), 32'd0);
    chk("cell_n5",   32'(n5),   32'(EXP_N5));
    chk("cell_n6",   32'(n6),   32'(EXP_N6_ANY));

    // ---- out-of-range writes are dropped ----
    do_write(3'd6, 3'd0, 3'd3);
    do_write(3'd7, 3'd7, 3'd3);
    do_write(3'd6, 3'd5, 3'd3);
    scan_frame("oor", mism, n5, n6);
    chk("oor_mism", 32'(mism), 32'd0);
    chk("oor_n5",   32'(n5),   32'(EXP_N5));

    // ---- same-edge write/read of cell (1,1) at pixel x=5,y=3 ----
    wait_sfs("rw_fs");
    repeat (2 * 124) @(negedge clk);   // output pixel t=124
    @(negedge clk);
    wr_en = 1'b1; wr_row = 3'd1; wr_col = 3'd1; wr_code = 3'd7;
    @(negedge clk);                    // output pixel t=125, read on write edge
    wr_en = 1'b0;
    chk("rw_tick", 32'(s_pt),   32'd1);
    chk("rw_old",  32'(s_code), 32'd0);
    repeat (2) @(negedge clk);         // output pixel t=126
    chk("rw_new",  32'(s_code), 32'd7);
    model[1*8+1] = 3'd7;
    scan_frame("rw", mism, n5, n6);
    chk("rw_mism", 32'(mism), 32'd0);

    // ---- reset mid-frame (line 8) ----
    wait_sfs("mid_fs");
    repeat (2 * 8 * SH_TOT) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("mid_hsync", 32'(s_hs),   32'd1);
    chk("mid_vsync", 32'(s_vs),   32'd1);
    chk("mid_blank", 32'(s_bn),   32'd0);
    chk("mid_code",  32'(s_code), 32'd0);
    chk("mid_tick",  32'(s_pt),   32'd0);
    chk("mid_fs0",   32'(s_fs),   32'd0);
    repeat (3) @(negedge clk);
    chk("mid_fs_early", 32'(s_fs), 32'd0);
    @(negedge clk);
    chk("mid_fs_at4",   32'(s_fs),   32'd1);
    chk("mid_bn_at4",   32'(s_bn),   32'd1);
    chk("mid_code_at4", 32'(s_code), 32'(ORIGIN_CODE));
    for (int i = 0; i < 48; i++) model[i] = 3'd0;
    scan_frame("clr", mism, n5, n6);
    chk("clr_mism", 32'(mism), 32'd0);
    chk("clr_n5",   32'(n5),   32'd0);
    chk("clr_n6",   32'(n6),   32'(EXP_N6_ANY));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/vga_code_gen.md
# vga_code_gen

Pixel-stream generator that sits directly upstream of the colour decoder in the VGA path. It produces 640x480@60 Hz sync timing from the 50 MHz system clock and keeps a board memory of ROWS x COLS 3-bit colour codes, written by game logic. Each cycle it emits the 3-bit code of the cell under the current pixel, pipeline-aligned with hsync, vsync and blank_n, for the decoder to expand into 8-bit R/G/B.

## Interface
- H_ACTIVE, 640, visible pixels per line
- H_FP / H_SYNC / H_BP, 16 / 96 / 48, horizontal porch and sync widths in pixels
- V_ACTIVE, 480, visible lines
- V_FP / V_SYNC / V_BP, 10 / 2 / 33, vertical porch and sync widths in lines
- CELL_W / CELL_H, 80 / 80, cell size in pixels
- COLS / ROWS, 8 / 6, board dimensions
- clk  in  1  system clock, 50 MHz
- rst_n  in  1  reset, synchronous, active-low
- wr_en  in  1  board write strobe
- wr_row  in  3  target row
- wr_col  in  3  target column
- wr_code  in  3  code to store
- hsync  out  1  horizontal sync, active-low
- vsync  out  1  vertical sync, active-low
- blank_n  out  1  high while the output pixel is visible
- code  out  3  colour code for the output pixel, input to the decoder
- pix_tick  out  1  one-clk pulse marking each new output pixel, used as DAC clock enable
- frame_start  out  1  one-clk pulse when the output pixel is (0,0)

## Operation
- Tick divider: phase toggles every clk. A pixel tick occurs when phase = 1. All counters and pipeline stages advance only on ticks.
- Counters: h runs 0..799 and wraps. v increments when h wraps, runs 0..524 and wraps.
- Raw sync:
  - hsync low for h in [656,751].
  - vsync low for v in [490,491].
  - Visible when h < 640 and v < 480.
- Cell index: tracked with sub-counters (x_sub 0..CELL_W-1 with cell_col, y_sub with cell_row), reset at h=0 / v=0. No divider is used.
- Pipeline:
  - S0: counters.
  - S1: registers cell_row, cell_col, sub-counters, raw sync and visible.
  - S2: reads the board, registers code, and drives all outputs.
- Board: 48-entry register file of 3-bit codes.
  - A write takes effect on the clk edge where wr_en=1, regardless of phase.
  - A write with wr_row >= ROWS or wr_col >= COLS is ignored.
  - Read and write of the same cell in the same cycle: the read returns the old value.
- Blanked pixels output code = 0.
- Reset mid-frame: on the next clk all counters, the phase, the pipeline and the board return to their reset state, and the frame restarts from (0,0).

## Timing
- Reset values:
  - hsync=1, vsync=1, blank_n=0, code=0, pix_tick=0, frame_start=0.
  - Board cleared to all 0.
  - h=v=0, phase=0.
- Pixel period: 2 clk. pix_tick is high on the clk after each tick edge.
- Latency: outputs for counter position (h,v) appear 2 ticks (4 clk) after the counters hold (h,v).
  - hsync, vsync, blank_n and code are always mutually aligned.
- The first output pixel (0,0) after reset is presented 4 clk after rst_n rises. frame_start pulses for exactly 1 clk at that point.
- Line = 800 ticks = 1600 clk. Frame = 525 lines.
- hsync low lasts 96 ticks. vsync low lasts 2 lines, starting at output h=0 of line 490.
- A board write is visible on any output pixel whose S2 read occurs after the write edge.

## Configuration
- GRID_LINES_EN defined: a visible pixel with x_sub=0 or y_sub=0 outputs code 6 (grey) instead of the cell content, giving a 1-pixel grid on cell boundaries.
- GRID_LINES_EN undefined: every visible pixel outputs its cell's stored code.

## Test plan
- Reset values: hold rst_n=0 for 10 clk, then check all outputs equal their reset values. Release, and check frame_start rises exactly 4 clk later with blank_n=1 and code=0.
- Line timing: count pix_tick between hsync falling edges, expect 800. hsync low for 96 ticks. blank_n high for 640 ticks per visible line.
- Frame timing: count lines between vsync falling edges, expect 525. vsync low for 2 lines. blank_n=0 during all lines 480..524.
- Cell write: write (row 2, col 3) = 5, wait one frame. Expect code=5 for x 240..319, y 160..239 (excluding the grid line when GRID_LINES_EN is defined) and code=0 elsewhere.
- Out-of-range write: write row 6 or col 7 row 7 with code 3. Expect no change anywhere on the board. Same-cycle read/write returns the old value for that pixel.
- Reset mid-frame: assert rst_n=0 at line 300 after writing cells, hold 1 clk. Expect the board cleared, outputs back to reset values, and frame_start again 4 clk after release. With GRID_LINES_EN defined, x=0/80/160 output code 6.
